// File: rtl/predistort_taps_loader.sv
// Shadow tap RAM written over the settings bus and replayed as one AXI-stream packet per commit.
// Optional build macro PD_TAPS_CHECKSUM_EN adds a per-packet mod-256 checksum in rb_data[31:24].
module predistort_taps_loader #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned DEPTH       = 7,
    parameter int unsigned SR_TAP_DATA = 0,
    parameter int unsigned SR_CTRL     = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             set_stb,
    input  logic [7:0]       set_addr,
    input  logic [31:0]      set_data,
    output logic [WIDTH-1:0] taps_tdata,
    output logic             taps_tlast,
    output logic             taps_tvalid,
    input  logic             taps_tready,
    output logic             busy,
    output logic [31:0]      rb_data
);

    localparam int unsigned N = 1 << DEPTH;
    localparam logic [DEPTH-1:0] LAST_ADDR = DEPTH'(N - 1);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [DEPTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic               wr_err_q, wr_err_d;
    logic               pending_q, pending_d;
    logic               busy_q, busy_d;
    logic               iss_active_q, iss_active_d;
    logic [DEPTH-1:0]   rd_addr_q, rd_addr_d;
    logic               rd_vld_q, rd_vld_d;
    logic               rd_last_q, rd_last_d;
    logic [WIDTH-1:0]   rd_data_q;
    logic               out_vld_q, out_vld_d;
    logic               out_last_q, out_last_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               skid_vld_q, skid_vld_d;
    logic               skid_last_q, skid_last_d;
    logic [WIDTH-1:0]   skid_data_q, skid_data_d;
    logic [31:0]        rb_q, rb_d;
    logic [7:0]         cks_c;

    logic [WIDTH-1:0]   mem [N];

    logic               tap_wr_c, ctrl_wr_c, commit_c, tap_we_c;
    logic               pop_c, can_issue_c, start_idle_c, start_rep_c, start_c, issue_c;
    logic [2:0]         occ_c;
    logic [DEPTH-1:0]   rd_addr_c;
    logic               unused_set_data_c;

    assign unused_set_data_c = ^set_data[31:WIDTH];

    // Settings decode and read-issue control
    always_comb begin
        tap_wr_c     = set_stb && (set_addr == 8'(SR_TAP_DATA));
        ctrl_wr_c    = set_stb && (set_addr == 8'(SR_CTRL));
        commit_c     = ctrl_wr_c && set_data[0];
        tap_we_c     = tap_wr_c && (state_q == S_IDLE) && !clear;
        pop_c        = out_vld_q && taps_tready;
        // Reads in flight plus buffered beats never exceed the two output slots
        occ_c        = 3'(out_vld_q) + 3'(skid_vld_q) + 3'(rd_vld_q);
        can_issue_c  = (occ_c - 3'(pop_c)) < 3'd2;
        start_idle_c = (state_q == S_IDLE) && commit_c;
        start_rep_c  = (state_q == S_STREAM) && !iss_active_q && pending_q && can_issue_c;
        start_c      = start_idle_c || start_rep_c;
        issue_c      = !clear && (start_c || (iss_active_q && can_issue_c));
        rd_addr_c    = start_c ? '0 : rd_addr_q;
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        wr_err_d     = wr_err_q;
        pending_d    = pending_q;
        iss_active_d = iss_active_q;
        rd_addr_d    = rd_addr_q;
        rd_vld_d     = issue_c;
        rd_last_d    = rd_last_q;
        out_vld_d    = out_vld_q;
        out_last_d   = out_last_q;
        out_data_d   = out_data_q;
        skid_vld_d   = skid_vld_q;
        skid_last_d  = skid_last_q;
        skid_data_d  = skid_data_q;

        if (issue_c) begin
            rd_addr_d    = rd_addr_c + DEPTH'(1);
            iss_active_d = (rd_addr_c != LAST_ADDR);
            rd_last_d    = (rd_addr_c == LAST_ADDR);
        end

        // Two-slot output skid: out_* drives the port, skid_* absorbs the read in flight
        if (!out_vld_q || pop_c) begin
            if (skid_vld_q) begin
                out_vld_d  = 1'b1;
                out_data_d = skid_data_q;
                out_last_d = skid_last_q;
                skid_vld_d = rd_vld_q;
                if (rd_vld_q) begin
                    skid_data_d = rd_data_q;
                    skid_last_d = rd_last_q;
                end
            end else begin
                out_vld_d = rd_vld_q;
                if (rd_vld_q) begin
                    out_data_d = rd_data_q;
                    out_last_d = rd_last_q;
                end else begin
                    out_last_d = 1'b0;
                end
            end
        end else if (rd_vld_q) begin
            skid_vld_d  = 1'b1;
            skid_data_d = rd_data_q;
            skid_last_d = rd_last_q;
        end

        if (tap_wr_c) begin
            if (state_q == S_STREAM) wr_err_d = 1'b1;
            else                     wr_ptr_d = wr_ptr_q + DEPTH'(1);
        end
        if (ctrl_wr_c) begin
            if (set_data[1]) wr_ptr_d = '0;
            if (set_data[2]) wr_err_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (commit_c) state_d = S_STREAM;
            end
            S_STREAM: begin
                if (start_rep_c) pending_d = 1'b0;
                if (commit_c)    pending_d = 1'b1;
                if (pop_c && out_last_q && !(iss_active_q || start_c || pending_q || commit_c))
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (clear) begin
            state_d      = S_IDLE;
            pending_d    = 1'b0;
            wr_ptr_d     = '0;
            wr_err_d     = 1'b0;
            iss_active_d = 1'b0;
            rd_vld_d     = 1'b0;
            out_vld_d    = 1'b0;
            out_last_d   = 1'b0;
            skid_vld_d   = 1'b0;
        end

        busy_d = (state_d == S_STREAM);

        rb_d            = '0;
        rb_d[DEPTH-1:0] = wr_ptr_q;
        rb_d[16]        = busy_q;
        rb_d[17]        = pending_q;
        rb_d[18]        = wr_err_q;
        rb_d[31:24]     = cks_c;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            wr_err_q     <= 1'b0;
            pending_q    <= 1'b0;
            busy_q       <= 1'b0;
            iss_active_q <= 1'b0;
            rd_addr_q    <= '0;
            rd_vld_q     <= 1'b0;
            rd_last_q    <= 1'b0;
            out_vld_q    <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
            skid_vld_q   <= 1'b0;
            skid_last_q  <= 1'b0;
            skid_data_q  <= '0;
            rb_q         <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            wr_err_q     <= wr_err_d;
            pending_q    <= pending_d;
            busy_q       <= busy_d;
            iss_active_q <= iss_active_d;
            rd_addr_q    <= rd_addr_d;
            rd_vld_q     <= rd_vld_d;
            rd_last_q    <= rd_last_d;
            out_vld_q    <= out_vld_d;
            out_last_q   <= out_last_d;
            out_data_q   <= out_data_d;
            skid_vld_q   <= skid_vld_d;
            skid_last_q  <= skid_last_d;
            skid_data_q  <= skid_data_d;
            rb_q         <= rb_d;
        end
    end

    // Shadow RAM: contents survive reset and clear
    always_ff @(posedge clk) begin
        if (tap_we_c) mem[wr_ptr_q] <= set_data[WIDTH-1:0];
        if (issue_c)  rd_data_q     <= mem[rd_addr_c];
    end

`ifdef PD_TAPS_CHECKSUM_EN
    logic [7:0] acc_q, acc_d, cks_q, cks_d;

    always_comb begin
        acc_d = acc_q;
        cks_d = cks_q;
        if (pop_c) begin
            if (out_last_q) begin
                cks_d = acc_q + out_data_q[7:0];
                acc_d = 8'd0;
            end else begin
                acc_d = acc_q + out_data_q[7:0];
            end
        end
        if (clear) acc_d = 8'd0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= 8'd0;
            cks_q <= 8'd0;
        end else begin
            acc_q <= acc_d;
            cks_q <= cks_d;
        end
    end

    assign cks_c = cks_q;
`else
    assign cks_c = 8'd0;
`endif

    assign taps_tdata  = out_data_q;
    assign taps_tlast  = out_last_q;
    assign taps_tvalid = out_vld_q;
    assign busy        = busy_q;
    assign rb_data     = rb_q;

endmodule

// File: tb/tb_predistort_taps_loader.sv
// Scoreboard bench for predistort_taps_loader: stimulus queues expected beats, a negedge monitor checks them.
module tb_predistort_taps_loader;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 7;
    localparam int unsigned N     = 128;
`ifdef PD_TAPS_CHECKSUM_EN
    localparam logic [7:0] CKS_EXP = 8'hC0;
`else
    localparam logic [7:0] CKS_EXP = 8'h00;
`endif

    logic             clk = 1'b0;
    logic             reset_n;
    logic             clear;
    logic             set_stb;
    logic [7:0]       set_addr;
    logic [31:0]      set_data;
    logic [WIDTH-1:0] taps_tdata;
    logic             taps_tlast;
    logic             taps_tvalid;
    logic             taps_tready;
    logic             busy;
    logic [31:0]      rb_data;

    always #5 clk = ~clk;

    predistort_taps_loader #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .SR_TAP_DATA(0), .SR_CTRL(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .taps_tdata(taps_tdata), .taps_tlast(taps_tlast), .taps_tvalid(taps_tvalid),
        .taps_tready(taps_tready), .busy(busy), .rb_data(rb_data)
    );

    int checks = 0;
    int errors = 0;
    int beats  = 0;
    int cyc    = 0;
    int tready_mode = 0;
    logic [16:0]      exp_q [$];
    logic [WIDTH-1:0] shadow [N];
    int mptr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
        end
    endtask

    // Monitor: pop one expectation per handshake, and hold-check stalled beats
    logic        prev_stall = 1'b0;
    logic [16:0] prev_beat  = '0;
    always @(negedge clk) begin
        if (!reset_n || clear) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("stall_hold", {14'b0, taps_tvalid, taps_tlast, taps_tdata}, {14'b0, 1'b1, prev_beat});
            if (taps_tvalid && taps_tready) begin
                beats++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat: got 0x%0h with no beat expected", {taps_tlast, taps_tdata});
                end else begin
                    chk("beat", {15'b0, taps_tlast, taps_tdata}, {15'b0, exp_q.pop_front()});
                end
            end
            prev_stall = taps_tvalid && !taps_tready;
            prev_beat  = {taps_tlast, taps_tdata};
        end
    end

    initial begin
        taps_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (tready_mode == 1) taps_tready = ~taps_tready;
            else                  taps_tready = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input logic [7:0] a, input logic [31:0] d);
        set_stb  = 1'b1;
        set_addr = a;
        set_data = d;
        tick();
        set_stb  = 1'b0;
        set_addr = 8'd0;
        set_data = 32'd0;
    endtask

    task automatic write_tap(input logic [15:0] d, input bit upd);
        set_wr(8'd0, {16'd0, d});
        if (upd) begin
            shadow[mptr] = d;
            mptr = (mptr + 1) % N;
        end
    endtask

    task automatic push_packet();
        for (int i = 0; i < N; i++) exp_q.push_back({(i == N - 1), shadow[i]});
    endtask

    task automatic wait_drain(input string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < 4000) begin
            tick();
            n++;
        end
        chk(nm, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_beats(input int target, input string nm);
        int n = 0;
        while (beats < target && n < 4000) begin
            tick();
            n++;
        end
        chk(nm, 32'(beats >= target), 32'd1);
    endtask

    initial begin
        int t0;
        int base;
        int gaps;
        int bubbles;
        int n;
        reset_n  = 1'b0;
        clear    = 1'b0;
        set_stb  = 1'b0;
        set_addr = 8'd0;
        set_data = 32'd0;
        #3;
        chk("rst_tvalid", 32'(taps_tvalid), 32'd0);
        chk("rst_tlast", 32'(taps_tlast), 32'd0);
        chk("rst_tdata", 32'(taps_tdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rb", rb_data, 32'd0);
        #9 reset_n = 1'b1;
        tick();

        // Test 1: full load, continuous ready
        for (int i = 0; i < N; i++) write_tap(16'(16'h0100 + i), 1'b1);
        tick();
        tick();
        chk("t1_ptr_wrap", 32'(rb_data[6:0]), 32'd0);
        push_packet();
        set_wr(8'd1, 32'd1);
        chk("t1_busy_rise", 32'(busy), 32'd1);
        chk("t1_lat_early", 32'(taps_tvalid), 32'd0);
        tick();
        chk("t1_lat_first", 32'(taps_tvalid), 32'd1);
        t0 = cyc;
        wait_drain("t1_drain");
        chk("t1_cycles", 32'(cyc - t0), 32'd128);
        chk("t1_busy_fall", 32'(busy), 32'd0);
        chk("t1_tvalid_low", 32'(taps_tvalid), 32'd0);
        tick();
        tick();
        chk("t1_cksum", 32'(rb_data[31:24]), 32'(CKS_EXP));
        chk("t1_rb_busy", 32'(rb_data[16]), 32'd0);

        // Test 2: ready toggles every cycle
        tready_mode = 1;
        push_packet();
        set_wr(8'd1, 32'd1);
        wait_drain("t2_drain");
        tick();
        tick();
        chk("t2_busy_fall", 32'(busy), 32'd0);
        tready_mode = 0;
        tick();

        // Test 3: second commit mid-packet restarts with no gap
        base = beats;
        push_packet();
        push_packet();
        set_wr(8'd1, 32'd1);
        wait_beats(base + 40, "t3_reach40");
        set_wr(8'd1, 32'd1);
        tick();
        chk("t3_pending", 32'(rb_data[17]), 32'd1);
        gaps = 0;
        bubbles = 0;
        n = 0;
        while (exp_q.size() != 0 && n < 4000) begin
            if (!busy) gaps++;
            if (!taps_tvalid) bubbles++;
            tick();
            n++;
        end
        chk("t3_drain", 32'(exp_q.size()), 32'd0);
        chk("t3_busy_gap", 32'(gaps), 32'd0);
        chk("t3_bubbles", 32'(bubbles), 32'd0);
        tick();
        tick();
        chk("t3_busy_fall", 32'(busy), 32'd0);
        chk("t3_pending_clr", 32'(rb_data[17]), 32'd0);

        // Test 4: tap write during stream is dropped and flagged
        base = beats;
        push_packet();
        set_wr(8'd1, 32'd1);
        wait_beats(base + 10, "t4_reach10");
        write_tap(16'hDEAD, 1'b0);
        tick();
        chk("t4_wr_err", 32'(rb_data[18]), 32'd1);
        chk("t4_ptr_kept", 32'(rb_data[6:0]), 32'd0);
        wait_drain("t4_drain");
        push_packet();
        set_wr(8'd1, 32'd1);
        wait_drain("t4_replay");
        set_wr(8'd1, 32'd4);
        tick();
        chk("t4_err_clr", 32'(rb_data[18]), 32'd0);

        // Test 5: 130 writes wrap the pointer
        for (int i = 0; i < 130; i++) write_tap(16'(16'h2000 + i), 1'b1);
        tick();
        chk("t5_ptr2", 32'(rb_data[6:0]), 32'd2);
        set_wr(8'd1, 32'd2);
        mptr = 0;
        tick();
        chk("t5_ptr_rst", 32'(rb_data[6:0]), 32'd0);
        push_packet();
        set_wr(8'd1, 32'd1);
        wait_drain("t5_drain");

        // Test 6a: soft clear at beat 60
        base = beats;
        push_packet();
        set_wr(8'd1, 32'd1);
        wait_beats(base + 60, "t6_reach60");
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("t6_clr_tvalid", 32'(taps_tvalid), 32'd0);
        chk("t6_clr_busy", 32'(busy), 32'd0);
        exp_q.delete();
        tick();
        tick();
        chk("t6_clr_tvalid2", 32'(taps_tvalid), 32'd0);
        chk("t6_clr_rb", rb_data & 32'h00FF_FFFF, 32'd0);

        // Test 6b: async reset at beat 60
        base = beats;
        push_packet();
        set_wr(8'd1, 32'd1);
        wait_beats(base + 60, "t6_reach60_rst");
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_tvalid", 32'(taps_tvalid), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_rb", rb_data, 32'd0);
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // RAM survives clear and reset
        push_packet();
        set_wr(8'd1, 32'd1);
        wait_drain("t6_recover");
        tick();
        tick();
        chk("t6_cksum", 32'(rb_data[31:24]), 32'(CKS_EXP));
        chk("t6_busy_end", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
